in_fsm: RTL and testbench

Receive-side nibble-to-byte framer for the PHY link: samples a 4-bit nibble stream plus a data-valid strobe on the PHY clock, hunts for preamble and start-of-frame delimiter, extracts the 24-bit control block, and emits payload bytes one at a time. It is the counterpart of the transmit output FSM, which serialises bytes to nibbles and prepends preamble/SFD and control block. It also maintains a received-frame sequence counter and flags each frame good or bad at its end.

---
 rtl/in_fsm.sv | 158 +++++++++++++++
 tb/tb_in_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/in_fsm.sv
// Receive-side nibble-to-byte framer: preamble/SFD hunt, 24-bit control block, payload bytes.
// Optional CRC-32 frame check is compiled in with IN_FSM_CRC_EN.
module in_fsm #(
  parameter int MIN_PREAMBLE = 2,
  parameter int MAX_BYTES    = 1518,
  parameter int SEQ_W        = 8
) (
  input  logic             clk_phy,
  input  logic             rst_n,
  input  logic [3:0]       data_in,
  input  logic             data_valid,
  output logic [7:0]       data_out,
  output logic             data_out_valid,
  output logic [23:0]      ctrl_block_out,
  output logic             ctrl_valid,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [SEQ_W-1:0] frame_seq_out
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [3:0] MIN_P = 4'(MIN_PREAMBLE);

  typedef enum logic [2:0] {IDLE, PREAMBLE, CTRL, PAYLOAD, DRAIN} state_t;

  state_t           state;
  logic [3:0]       pre_cnt;
  logic [3:0]       low_nib;
  logic             half;
  logic [CNT_W-1:0] byte_cnt;
  logic [15:0]      ctrl_sr;

  logic [7:0] full_byte;
  logic       byte_over;
  logic       in_frame;
  logic       sfd_hit;
  logic       byte_done;
  logic       frame_good;

  assign full_byte = {data_in, low_nib};
  // the byte being completed would be number MAX_BYTES+1
  assign byte_over = (byte_cnt == CNT_W'(MAX_BYTES));
  assign in_frame  = (state == CTRL) || (state == PAYLOAD);
  assign sfd_hit   = (state == PREAMBLE) && data_valid && (data_in == 4'hD) && (pre_cnt >= MIN_P);
  assign byte_done = in_frame && data_valid && half && !byte_over;

`ifdef IN_FSM_CRC_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 32'hFFFFFFFF;
    end else if (sfd_hit) begin
      crc <= 32'hFFFFFFFF;
    end else if (byte_done) begin
      crc <= crc32_byte(crc, full_byte);
    end
  end

  // residue over data+FCS, and at least 4 payload bytes behind the control block
  assign frame_good = (crc == 32'hDEBB20E3) && (byte_cnt >= CNT_W'(7));
`else
  assign frame_good = 1'b1;
`endif

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pre_cnt        <= 4'd0;
      low_nib        <= 4'd0;
      half           <= 1'b0;
      byte_cnt       <= '0;
      ctrl_sr        <= 16'h0000;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      ctrl_block_out <= 24'h000000;
      ctrl_valid     <= 1'b0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      frame_seq_out  <= '0;
    end else begin
      data_out_valid <= 1'b0;
      ctrl_valid     <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid) begin
            if (data_in == 4'h5) begin
              state   <= PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        PREAMBLE: begin
          if (!data_valid) begin
            state <= IDLE;
          end else if (data_in == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (sfd_hit) begin
            state    <= CTRL;
            half     <= 1'b0;
            byte_cnt <= '0;
          end else begin
            state <= DRAIN;
          end
        end
        CTRL, PAYLOAD: begin
          if (!data_valid) begin
            frame_done <= 1'b1;
            state      <= IDLE;
            if ((state == PAYLOAD) && !half && frame_good) begin
              frame_ok      <= 1'b1;
              frame_seq_out <= frame_seq_out + 1'b1;
            end else begin
              frame_ok <= 1'b0;
            end
          end else if (!half) begin
            low_nib <= data_in;
            half    <= 1'b1;
          end else if (byte_over) begin
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            state      <= DRAIN;
          end else begin
            half     <= 1'b0;
            byte_cnt <= byte_cnt + 1'b1;
            if (state == PAYLOAD) begin
              data_out       <= full_byte;
              data_out_valid <= 1'b1;
            end else if (byte_cnt == CNT_W'(2)) begin
              ctrl_block_out <= {ctrl_sr, full_byte};
              ctrl_valid     <= 1'b1;
              state          <= PAYLOAD;
            end else begin
              ctrl_sr <= {ctrl_sr[7:0], full_byte};
            end
          end
        end
        DRAIN: begin
          if (!data_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_fsm.sv
// Scoreboard bench for in_fsm: stimulus pushes expected bytes/control/frame results, a monitor pops them.
module tb_in_fsm;

`ifdef IN_FSM_CRC_EN
  localparam bit PLAIN_OK = 1'b0;
`else
  localparam bit PLAIN_OK = 1'b1;
`endif

  logic       clk_phy = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [23:0] ctrl_block_out;
  logic       ctrl_valid;
  logic       frame_done;
  logic       frame_ok;
  logic [7:0] frame_seq_out;

  always #5 clk_phy = ~clk_phy;

  in_fsm dut (
    .clk_phy(clk_phy), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .ctrl_block_out(ctrl_block_out), .ctrl_valid(ctrl_valid),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_seq_out(frame_seq_out)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  q_byte[$];
  logic [23:0] q_ctrl[$];
  logic [8:0]  q_frm[$];
  logic [7:0]  exp_seq = 8'h00;
  logic [7:0]  pay [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=no pulse", name, act);
  endtask

  // monitor: every output pulse must match the head of its queue
  always @(negedge clk_phy) begin
    if (rst_n) begin
      if (data_out_valid) begin
        if (q_byte.size() == 0) extra("byte_extra", 32'(data_out));
        else check("byte", 32'(data_out), 32'(q_byte.pop_front()));
      end
      if (ctrl_valid) begin
        if (q_ctrl.size() == 0) extra("ctrl_extra", 32'(ctrl_block_out));
        else check("ctrl", 32'(ctrl_block_out), 32'(q_ctrl.pop_front()));
      end
      if (frame_done) begin
        if (q_frm.size() == 0) extra("frame_extra", 32'({frame_ok, frame_seq_out}));
        else check("frame_ok_seq", 32'({frame_ok, frame_seq_out}), 32'(q_frm.pop_front()));
      end
    end
  end

  task automatic nib(input logic v, input logic [3:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk_phy);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(1'b1, b[3:0]);
    nib(1'b1, b[7:4]);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
  endtask

  task automatic frame(input logic [23:0] c, input int n, input bit trail, input bit ok);
    q_ctrl.push_back(c);
    for (int i = 0; i < n; i++) q_byte.push_back(pay[i]);
    if (ok) exp_seq = exp_seq + 8'd1;
    q_frm.push_back({ok, exp_seq});
    preamble();
    send_byte(c[23:16]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
    for (int i = 0; i < n; i++) send_byte(pay[i]);
    if (trail) nib(1'b1, 4'h7);
    nib(1'b0, 4'h0);
  endtask

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  initial begin
    logic [31:0] fcs;
    rst_n = 1'b0; data_valid = 1'b0; data_in = 4'h0;
    @(negedge clk_phy);
    check("reset_outputs", 32'({data_out, data_out_valid, ctrl_valid, frame_done, frame_ok, frame_seq_out}), 32'h0);
    check("reset_ctrl", 32'(ctrl_block_out), 32'h0);
    @(posedge clk_phy); #1;
    rst_n = 1'b1;
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h0);

    // basic frame, then a zero-payload frame back-to-back
    pay[0] = 8'hA5; pay[1] = 8'h3C;
    frame(24'h123456, 2, 1'b0, PLAIN_OK);
    frame(24'h0F0E0D, 0, 1'b0, PLAIN_OK);
    nib(1'b0, 4'h0);
    check("seq_after_two", 32'(frame_seq_out), 32'(exp_seq));

    // short preamble: single 5 then D goes to DRAIN
    nib(1'b1, 4'h5); nib(1'b1, 4'hD);
    nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'hD); nib(1'b1, 4'h1);
    nib(1'b0, 4'h0); nib(1'b0, 4'h0);
    check("seq_short_pre", 32'(frame_seq_out), 32'(exp_seq));

    // odd trailing nibble
    pay[0] = 8'h81; pay[1] = 8'hFE;
    frame(24'hA1B2C3, 2, 1'b1, 1'b0);
    nib(1'b0, 4'h0);
    check("seq_odd", 32'(frame_seq_out), 32'(exp_seq));

    // overflow: 3 control + 1516 payload bytes, only 1515 emitted
    q_ctrl.push_back(24'hC0FFEE);
    for (int i = 0; i < 1515; i++) q_byte.push_back(8'(i));
    q_frm.push_back({1'b0, exp_seq});
    preamble();
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hEE);
    for (int i = 0; i < 1516; i++) send_byte(8'(i));
    for (int i = 0; i < 6; i++) nib(1'b1, 4'h5);
    nib(1'b0, 4'h0); nib(1'b0, 4'h0);
    check("seq_overflow", 32'(frame_seq_out), 32'(exp_seq));

    // reset during payload byte 5
    q_ctrl.push_back(24'h9A8B7C);
    q_byte.push_back(8'h11); q_byte.push_back(8'h22);
    q_byte.push_back(8'h33); q_byte.push_back(8'h44);
    preamble();
    send_byte(8'h9A); send_byte(8'h8B); send_byte(8'h7C);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    nib(1'b1, 4'h6);
    rst_n = 1'b0;
    @(negedge clk_phy);
    check("midreset_outputs", 32'({data_out, data_out_valid, ctrl_valid, frame_done, frame_ok, frame_seq_out}), 32'h0);
    check("midreset_ctrl", 32'(ctrl_block_out), 32'h0);
    @(posedge clk_phy); #1;
    rst_n = 1'b1;
    exp_seq = 8'h00;
    nib(1'b1, 4'h6); nib(1'b1, 4'h7); nib(1'b1, 4'h7);
    nib(1'b0, 4'h0);
    pay[0] = 8'h42; pay[1] = 8'h24;
    frame(24'h010203, 2, 1'b0, PLAIN_OK);
    nib(1'b0, 4'h0);
    check("seq_after_reset", 32'(frame_seq_out), 32'(exp_seq));

`ifdef IN_FSM_CRC_EN
    fcs = 32'hFFFFFFFF;
    fcs = crc_bits(fcs, 8'h12); fcs = crc_bits(fcs, 8'h34); fcs = crc_bits(fcs, 8'h56);
    for (int i = 0; i < 4; i++) fcs = crc_bits(fcs, 8'h00);
    fcs = ~fcs;
    for (int i = 0; i < 4; i++) pay[i] = 8'h00;
    pay[4] = fcs[7:0]; pay[5] = fcs[15:8]; pay[6] = fcs[23:16]; pay[7] = fcs[31:24];
    frame(24'h123456, 8, 1'b0, 1'b1);
    pay[5] = pay[5] ^ 8'h04;
    frame(24'h123456, 8, 1'b0, 1'b0);
`else
    fcs = crc_bits(32'hFFFFFFFF, 8'h00);
`endif

    repeat (5) nib(1'b0, 4'h0);
    check("bytes_left", 32'(q_byte.size()), 32'd0);
    check("ctrl_left", 32'(q_ctrl.size()), 32'd0);
    check("frames_left", 32'(q_frm.size()), 32'd0);
    check("seq_final", 32'(frame_seq_out), 32'(exp_seq));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
